// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan display path:
//   - SEG_TABLE : 16-entry active-low {g,f,e,d,c,b,a} patterns for hex 0..F
//   - SEG_OFF   : all segments dark
//   - AN_OFF    : all anodes disabled (active-low)
//   - scan_state_e : scan controller states
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Packed so that SEG_TABLE[n] is the pattern for hex digit n
    // (entries listed from F down to 0).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_e;

endpackage : seg_pkg

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Purely combinational hex to 7-segment decoder, active-low outputs.
// Ports:
//   digit : 4-bit hex value
//   seg   : 7-bit segment pattern {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup; every 4-bit code has an entry so no fallback is needed.
    always_comb begin
        seg = SEG_OFF;
        seg = SEG_TABLE[digit];
    end

endmodule : seg7_decode

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Each digit slot lasts SCAN_DIV cycles: the first BLANK_CYCLES
// keep every anode off (dead time against ghosting, and it hides the
// one-cycle decode latency), the remainder drive the selected anode.
// All outputs are registered.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   EN          : scan enable, 0 = display dark and scan restarts at slot 0
//   DIGIT_IN    : digit chosen by the external 4:1 mux from SEL (same cycle)
//   DP_MASK     : per-digit decimal point enable
//   BLANK_MASK  : per-digit forced-dark (leading-zero blanking)
//   SEL         : digit select to the external mux
//   AN          : anode enables, active-low
//   SEG         : segments {g,f,e,d,c,b,a}, active-low
//   DP          : decimal point, active-low
// ---------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [3:0] DIGIT_IN,
    input  logic [3:0] DP_MASK,
    input  logic [3:0] BLANK_MASK,
    output logic [1:0] SEL,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO       = CW'(0);
    localparam logic [CW-1:0] CNT_ONE        = CW'(1);

    scan_state_e   state_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    sel_r;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    logic [6:0]    seg_dec_s;
    logic [3:0]    an_on_s;
    logic          dp_on_s;

    seg7_decode u_decode (
        .digit (DIGIT_IN),
        .seg   (seg_dec_s)
    );

    // Anode and decimal-point values for the current slot while it is lit.
    always_comb begin
        an_on_s = AN_OFF;
        if (BLANK_MASK[sel_r]) begin
            an_on_s = AN_OFF;
        end else begin
            an_on_s = ~(4'b0001 << sel_r);
        end
        dp_on_s = ~DP_MASK[sel_r];
    end

    // Scan FSM: slot counter, digit select and registered display outputs.
    // Outputs are loaded with the value belonging to the next state so that
    // AN is low for exactly the ON portion of each slot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            sel_r   <= 2'd0;
            an_r    <= AN_OFF;
            seg_r   <= SEG_OFF;
            dp_r    <= 1'b1;
        end else if (!EN) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            sel_r   <= 2'd0;
            an_r    <= AN_OFF;
            seg_r   <= SEG_OFF;
            dp_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_BLANK;
                    cnt_r   <= CNT_ZERO;
                    sel_r   <= 2'd0;
                    an_r    <= AN_OFF;
                    seg_r   <= SEG_OFF;
                    dp_r    <= 1'b1;
                end
                ST_BLANK: begin
                    // SEG tracks the new digit during dead time so it is
                    // already settled when the anode turns on.
                    seg_r <= seg_dec_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_BLANK_LAST) begin
                        state_r <= ST_ON;
                        an_r    <= an_on_s;
                        dp_r    <= dp_on_s;
                    end else begin
                        state_r <= ST_BLANK;
                        an_r    <= AN_OFF;
                        dp_r    <= 1'b1;
                    end
                end
                ST_ON: begin
                    seg_r <= seg_dec_s;
                    if (cnt_r == CNT_SLOT_LAST) begin
                        state_r <= ST_BLANK;
                        cnt_r   <= CNT_ZERO;
                        sel_r   <= sel_r + 2'd1;
                        an_r    <= AN_OFF;
                        dp_r    <= 1'b1;
                    end else begin
                        state_r <= ST_ON;
                        cnt_r   <= cnt_r + CNT_ONE;
                        an_r    <= an_on_s;
                        dp_r    <= dp_on_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    sel_r   <= 2'd0;
                    an_r    <= AN_OFF;
                    seg_r   <= SEG_OFF;
                    dp_r    <= 1'b1;
                end
            endcase
        end
    end

    assign SEL = sel_r;
    assign AN  = an_r;
    assign SEG = seg_r;
    assign DP  = dp_r;

endmodule : seg_scan_driver
